udm_uart_tx: RTL
================

Name: udm_uart_tx

Overview:
- Transmit half of the UART debug link between the on-chip debug master (udm) and the host.
- Takes response bytes from the udm engine over a valid/ready byte stream and buffers them in a small FIFO.
- Serializes each byte onto tx_o as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing comes from a runtime divider, so host-side baud settings (115200/19200/9600/...) are reachable without resynthesis.

Parameters:
FIFO_DEPTH, 4, byte buffer entries (power of 2, >=2)
DIV_WIDTH, 32, width of bit_period_i

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
bit_period_i  in  DIV_WIDTH  clock cycles per UART bit; 0 treated as 1
parity_cfg_i  in  2  00/11 none, 01 even, 10 odd
stop2_i  in  1  0: one stop bit, 1: two stop bits
s_valid_i  in  1  byte offered
s_data_i  in  8  byte to send
s_ready_o  out  1  byte accepted when s_valid_i && s_ready_o at clk_i rise
tx_o  out  1  serial line, idle high, registered
busy_o  out  1  FIFO non-empty or frame in progress

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values while rst_i is high: tx_o=1, s_ready_o=1, busy_o=0, FIFO empty, FSM=IDLE, all counters 0.
- Reset mid-frame: the frame is abandoned immediately, tx_o returns to 1 asynchronously, and buffered bytes are discarded.
- FIFO:
  - s_ready_o = !full, computed from registered state only.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Push and pop in the same non-full cycle are both honoured; the count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Pop and latching:
  - IDLE with FIFO non-empty: pop into the shift register and move to START.
  - On pop, latch bit_period_i, parity_cfg_i and stop2_i for the whole frame. Config changes mid-frame do not affect that frame.
- Latency: a byte accepted into an empty FIFO in IDLE at edge N is popped at edge N+1, and tx_o falls after edge N+1.
- Bit counter:
  - Each state holds tx_o for exactly P = max(bit_period_i,1) cycles.
  - The bit-cycle counter runs 0..P-1; the state advances on P-1.
- States in order:
  - START: tx_o=0.
  - DATA: 8 bits LSB first; a 3-bit index wraps 7 -> exit.
  - PARITY: only if parity_cfg_i is 01 or 10. Even: bit = XOR of data bits. Odd: the inverse.
  - STOP: tx_o=1 for P cycles, or 2P cycles if stop2_i.
- Back-to-back frames: at the last cycle of STOP, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length is P*(10 + parity + stop2) cycles.
- busy_o is combinational from registered state: (count != 0) || (state != IDLE).
- No output glitches: tx_o is driven from a flop.

Decomposition:
- Package udm_uart_pkg:
  - parity enum: PAR_NONE, PAR_EVEN, PAR_ODD
  - FSM state enum
  - UART_DATA_BITS=8
- Sub-module udm_uart_tx_fifo: synchronous FIFO with ptr/count, push/pop, full/empty. It is reusable by the matching receive path.
- The FSM, bit counter and shifter stay in udm_uart_tx.

Test Plan:
- Basic frame: P=4, no parity, 1 stop; push 0x55 -> tx_o = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total; busy_o drops the cycle after the last stop cycle.
- Parity: P=4, even parity, push 0xA7 (five ones) -> parity bit 1, 44-cycle frame. Repeat with odd parity -> parity bit 0.
- Two stop bits: P=3, stop2_i=1, push 0x00 -> tx_o low for 27 cycles, then high for 6 cycles.
- Back-to-back and backpressure (FIFO_DEPTH=4, P=2):
  - Present 6 bytes 0x10..0x15 continuously.
  - Expect 5 accepted without stall (one in the shifter, 4 in the FIFO).
  - s_ready_o low until the stop of 0x10 completes.
  - Frames contiguous with no idle cycles; bytes emitted in order.
- Config latch: start a frame with P=4, change bit_period_i to 8 mid-DATA -> current frame keeps 4-cycle bits; the next frame uses 8.
- Reset mid-frame: assert rst_i during DATA with 3 bytes queued -> tx_o=1 and s_ready_o=1 without waiting for a clock edge; after release no bytes are sent and busy_o=0.
- Divider edge: bit_period_i=0 -> one cycle per bit, identical to P=1.

Source files
------------

// File: rtl/udm_uart_pkg.sv
// Shared types for the udm UART transmit/receive paths: frame state, parity
// selection and the data width of one character.
package udm_uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // 2'b11 is reserved and behaves as "no parity"
   function automatic parity_e decode_parity(input logic [1:0] cfg);
      case (cfg)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/udm_uart_tx_fifo.sv
// Small synchronous byte FIFO with pointer/count bookkeeping; a push into a
// full FIFO is refused even when a pop happens in the same cycle.
module udm_uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push_i && !full_o;
      pop_ok   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone says which entries are live
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/udm_uart_tx.sv
// UART transmitter for the udm debug link: buffers bytes from a valid/ready
// stream and serializes them as start / 8 data LSB-first / parity / stop(s).
module udm_uart_tx
   import udm_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DIV_WIDTH-1:0] bit_period_i,
   input  logic [1:0]           parity_cfg_i,
   input  logic                 stop2_i,
   input  logic                 s_valid_i,
   input  logic [7:0]           s_data_i,
   output logic                 s_ready_o,
   output logic                 tx_o,
   output logic                 busy_o
);

   // Handshake: a byte moves when s_valid_i && s_ready_o at a clk_i rise;
   // s_ready_o depends only on registered FIFO state.
   logic                      fifo_pop;
   logic [UART_DATA_BITS-1:0] fifo_rd_data;
   logic                      fifo_full;
   logic                      fifo_empty;

   udm_uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (s_valid_i),
      .wr_data_i (s_data_i),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   tx_state_e                 state_q, state_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]                bit_idx_q, bit_idx_d;
   logic [DIV_WIDTH-1:0]      cyc_q, cyc_d;
   logic [DIV_WIDTH-1:0]      period_q, period_d;
   parity_e                   parity_q, parity_d;
   logic                      stop2_q, stop2_d;
   logic                      stop_sec_q, stop_sec_d;
   logic                      par_bit_q, par_bit_d;
   logic                      tx_q, tx_d;

   logic [DIV_WIDTH-1:0]      eff_period;
   parity_e                   cfg_parity;
   logic                      bit_done;
   logic                      load_frame;

   assign eff_period = (bit_period_i == '0) ? DIV_WIDTH'(1) : bit_period_i;
   assign cfg_parity = decode_parity(parity_cfg_i);
   assign bit_done   = (cyc_q == period_q - DIV_WIDTH'(1));

   assign s_ready_o = !fifo_full;
   assign tx_o      = tx_q;
   assign busy_o    = !fifo_empty || (state_q != ST_IDLE);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      period_d   = period_q;
      parity_d   = parity_q;
      stop2_d    = stop2_q;
      stop_sec_d = stop_sec_q;
      par_bit_d  = par_bit_q;
      cyc_d      = bit_done ? '0 : cyc_q + DIV_WIDTH'(1);
      load_frame = 1'b0;
      fifo_pop   = 1'b0;
      tx_d       = 1'b1;

      case (state_q)
         ST_IDLE: begin
            cyc_d = '0;
            if (!fifo_empty) load_frame = 1'b1;
         end
         ST_START: begin
            if (bit_done) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                  state_d    = (parity_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                  stop_sec_d = 1'b0;
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               state_d    = ST_STOP;
               stop_sec_d = 1'b0;
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               if (stop2_q && !stop_sec_q) stop_sec_d = 1'b1;
               else if (!fifo_empty)       load_frame = 1'b1;
               else                        state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Frame configuration is captured together with the byte itself
      if (load_frame) begin
         fifo_pop   = 1'b1;
         state_d    = ST_START;
         shift_d    = fifo_rd_data;
         period_d   = eff_period;
         parity_d   = cfg_parity;
         stop2_d    = stop2_i;
         stop_sec_d = 1'b0;
         par_bit_d  = (^fifo_rd_data) ^ (cfg_parity == PAR_ODD);
         cyc_d      = '0;
      end

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_bit_d;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         cyc_q      <= '0;
         period_q   <= '0;
         parity_q   <= PAR_NONE;
         stop2_q    <= 1'b0;
         stop_sec_q <= 1'b0;
         par_bit_q  <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         cyc_q      <= cyc_d;
         period_q   <= period_d;
         parity_q   <= parity_d;
         stop2_q    <= stop2_d;
         stop_sec_q <= stop_sec_d;
         par_bit_q  <= par_bit_d;
         tx_q       <= tx_d;
      end
   end

endmodule
